rr_arbiter_8: RTL and testbench

- Round-robin arbiter over 8 requesters.
- Produces the registered 3-bit select index `idx` consumed directly by the 3x8 one-hot decoder stage (decoder input A = idx).
- Holds each grant until the owner signals `done`, or until a watchdog timeout forces release.
- Sits upstream of the decoder in the channel-select path.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_next_idx.sv | 41 ++++
 rtl/rr_arbiter_8.sv | 86 ++++++++
 tb/tb_rr_arbiter_8.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N      : number of requesters (fixed at 8 to match the 3x8 decoder)
//   IDX_W  : width of a requester index
//   IDLE / GRANT : FSM state encodings
package arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

endpackage

// File: rtl/rr_next_idx.sv
// Combinational round-robin search: finds the first set request bit
// starting just after the last owner and wrapping 7 -> 0.
// Ports:
//   req [7:0] : request vector
//   ptr [2:0] : index of the last released owner
//   nxt [2:0] : index chosen for the next grant (only meaningful when any=1)
//   any       : at least one request is set
module rr_next_idx
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] nxt,
  output logic             any
);

  logic [IDX_W-1:0] start;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // NOTE: every variable assigned here gets a value on every path first,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    start = ptr + 1'b1;
    rot   = '0;
    off   = '0;
    // Rotate so the requester right after ptr lands at bit 0; the index
    // truncation to IDX_W bits performs the modulo-8 wrap.
    for (int i = 0; i < N; i++) begin
      rot[i] = req[IDX_W'(i + int'(start))];
    end
    // Lowest set bit of the rotated vector wins: scan downward so the
    // last assignment is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    nxt = start + off;
    any = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter over 8 requesters with a watchdog on grant length.
// A grant is held until the owner pulses done or the grant has lasted
// TIMEOUT cycles; either way the bus goes idle for exactly one cycle and
// the releasing requester drops to lowest priority.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active-high
//   req     : request vector, bit i = requester i
//   done    : owner releases the grant (ignored while valid=0)
//   idx     : registered grant index, drives decoder input A
//   valid   : idx is a live grant
//   timeout : one-cycle pulse on a watchdog-forced release
//   busy    : combinational copy of valid
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] nxt;
  logic             any;

  rr_next_idx u_next (
    .req (req),
    .ptr (ptr),
    .nxt (nxt),
    .any (any)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      ptr     <= IDX_W'(N - 1);  // first search after reset starts at 0
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            idx   <= nxt;
            valid <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (done) begin
            // done has priority over the watchdog in the same cycle
            valid <= 1'b0;
            ptr   <= idx;
            state <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            valid   <= 1'b0;
            timeout <= 1'b1;
            ptr     <= idx;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (TIMEOUT=16).
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] idx;
  logic       valid;
  logic       timeout;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  rr_arbiter_8 #(.TIMEOUT(16), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .idx     (idx),
    .valid   (valid),
    .timeout (timeout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a full output snapshot (busy must always mirror valid).
  task automatic expect_out(input string tag, input logic v,
                            input logic [2:0] i, input logic t);
    check({tag, ".valid"}, 32'(valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(idx), 32'(i));
    check({tag, ".timeout"}, 32'(timeout), 32'(t));
    check({tag, ".busy"}, 32'(busy), 32'(v));
  endtask

  logic [2:0] rot_exp [4];

  initial begin
    rot_exp[0] = 3'd2; rot_exp[1] = 3'd5; rot_exp[2] = 3'd2; rot_exp[3] = 3'd5;

    // ---------------- reset ----------------
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    step();
    check("rst.idx", 32'(idx), 32'd0);
    expect_out("rst", 1'b0, 3'd0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("rst_rel", 1'b1, 3'd0, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0; req = 8'h00;
    expect_out("rst_done", 1'b0, 3'd0, 1'b0);
    // done while idle is ignored
    done = 1'b1;
    step();
    done = 1'b0;
    expect_out("idle_done", 1'b0, 3'd0, 1'b0);
    check("idle_hold_idx", 32'(idx), 32'd0);

    // ---------------- rotation: 2,5,2,5 ----------------
    req = 8'b0010_0100;
    for (int g = 0; g < 4; g++) begin
      step(); expect_out($sformatf("rot%0d.c1", g), 1'b1, rot_exp[g], 1'b0);
      step(); expect_out($sformatf("rot%0d.c2", g), 1'b1, rot_exp[g], 1'b0);
      step(); expect_out($sformatf("rot%0d.c3", g), 1'b1, rot_exp[g], 1'b0);
      done = 1'b1;
      step(); done = 1'b0;
      if (g == 3) req = 8'h00;
      expect_out($sformatf("rot%0d.gap", g), 1'b0, 3'd0, 1'b0);
    end

    // ---------------- wrap-around: 7, then 0, then 7 ----------------
    req = 8'b1000_0000;
    step(); expect_out("wrap.g7", 1'b1, 3'd7, 1'b0);
    done = 1'b1; step(); done = 1'b0;
    expect_out("wrap.gap0", 1'b0, 3'd0, 1'b0);
    req = 8'b1000_0001;
    step(); expect_out("wrap.g0", 1'b1, 3'd0, 1'b0);
    done = 1'b1; step(); done = 1'b0;
    expect_out("wrap.gap1", 1'b0, 3'd0, 1'b0);
    step(); expect_out("wrap.g7b", 1'b1, 3'd7, 1'b0);
    done = 1'b1; step(); done = 1'b0; req = 8'h00;
    expect_out("wrap.gap2", 1'b0, 3'd0, 1'b0);
    step(); expect_out("wrap.idle", 1'b0, 3'd0, 1'b0);

    // ---------------- timeout: 16 valid cycles then a pulse ----------------
    req = 8'b0000_1000;
    step();
    for (int c = 0; c < 16; c++) begin
      expect_out($sformatf("to.c%0d", c), 1'b1, 3'd3, 1'b0);
      step();
    end
    expect_out("to.pulse", 1'b0, 3'd0, 1'b1);
    step();
    expect_out("to.regrant", 1'b1, 3'd3, 1'b0);

    // ---------------- done exactly at the watchdog limit ----------------
    for (int c = 0; c < 15; c++) step();
    expect_out("lim.c15", 1'b1, 3'd3, 1'b0);
    done = 1'b1; step(); done = 1'b0; req = 8'h00;
    expect_out("lim.release", 1'b0, 3'd0, 1'b0);
    step();
    expect_out("lim.after", 1'b0, 3'd0, 1'b0);

    // ---------------- owner drops request mid-grant ----------------
    req = 8'b0000_0100;                    // ptr=3 -> scan from 4, finds 2
    step(); expect_out("drop.g", 1'b1, 3'd2, 1'b0);
    step(); step();
    req = 8'b0100_0000;                    // owner drops, another arrives
    for (int c = 0; c < 3; c++) begin
      step(); expect_out($sformatf("drop.hold%0d", c), 1'b1, 3'd2, 1'b0);
    end
    req = 8'h00; done = 1'b1; step(); done = 1'b0;
    expect_out("drop.rel", 1'b0, 3'd0, 1'b0);

    // ---------------- async reset mid-grant ----------------
    req = 8'b0001_0000;                    // ptr=2 -> grant 4
    step(); expect_out("ar.g", 1'b1, 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1 expect_out("ar.async", 1'b0, 3'd0, 1'b0);
    check("ar.idx", 32'(idx), 32'd0);
    #1 rst = 1'b0;
    req = 8'b0010_0001;                    // from reset ptr=7 the search picks 0
    step(); expect_out("ar.restart", 1'b1, 3'd0, 1'b0);
    done = 1'b1; step(); done = 1'b0; req = 8'h00;
    expect_out("ar.rel", 1'b0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
